axi_burst_addr_gen: RTL



---
 rtl/axi_burst_addr_gen_pkg.sv | 32 +++
 rtl/axi_burst_addr_gen_if.sv | 44 ++++
 rtl/axi_beat_addr_calc.sv | 34 +++
 rtl/axi_burst_addr_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI width parameters, burst-type encodings and the beat descriptor
// used by the burst address generator and its consumers.
package axi_burst_addr_gen_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 256;
    localparam int AXI_LEN_WIDTH  = 8;
    localparam int AXI_LANE_WIDTH = $clog2(AXI_DATA_WIDTH / 8);
    localparam int AXI_PAGE_BITS  = 12;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_LANE_WIDTH-1:0] lane;
        logic [AXI_LEN_WIDTH-1:0]  idx;
        logic                      last;
    } beat_desc_t;

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command, beat-descriptor and error signals of the burst address generator.
interface axi_burst_addr_gen_if
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ID_WIDTH   = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) ();

    localparam int LANE_WIDTH = $clog2(DATA_WIDTH / 8);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [2:0]            cmd_size;
    logic [1:0]            cmd_burst;

    logic                  beat_valid;
    logic                  beat_ready;
    logic [ID_WIDTH-1:0]   beat_id;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [LANE_WIDTH-1:0] beat_lane;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic                  beat_last;

    logic                  err_valid;
    logic [ID_WIDTH-1:0]   err_id;

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_id, beat_addr, beat_lane, beat_idx, beat_last,
        output err_valid, err_id
    );

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_id, beat_addr, beat_lane, beat_idx, beat_last,
        input  err_valid, err_id
    );

endinterface

// File: rtl/axi_beat_addr_calc.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_beat_addr_calc
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  burst_e                burst,
    input  logic [ADDR_WIDTH-1:0] wrap_lower,
    input  logic [ADDR_WIDTH-1:0] wrap_bytes,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_sum;

    always_comb begin
        step      = ONE << size;
        // INCR realigns after an unaligned first beat
        incr_addr = (addr & ~(step - ONE)) + step;
        wrap_sum  = addr + step;
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (wrap_sum == wrap_lower + wrap_bytes) ? wrap_lower : wrap_sum;
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address generator: accepts one burst command at a time and
// emits one beat descriptor per data transfer, rejecting illegal commands.
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ID_WIDTH   = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_burst_addr_gen_if.slave  bus
);

    localparam int                    LANE_WIDTH = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]            MAX_SIZE   = 3'(LANE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK  = (ONE << AXI_PAGE_BITS) - ONE;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    burst_e                burst_q, burst_d;
    logic [ADDR_WIDTH-1:0] wrap_lower_q, wrap_lower_d;
    logic [ADDR_WIDTH-1:0] wrap_bytes_q, wrap_bytes_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic                  err_valid_q, err_valid_d;
    logic [ID_WIDTH-1:0]   err_id_q, err_id_d;

    logic                  beat_valid, beat_last, beat_hs, cmd_ready, cmd_hs;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] cmd_size_mask, cmd_wrap_bytes, cmd_incr_end;
    logic                  cmd_wrap, cmd_wrap_len_ok, cmd_err;

    assign beat_valid = (state_q == ST_BURST);
    assign beat_last  = beat_valid && (idx_q == len_q);
    assign beat_hs    = beat_valid && bus.beat_ready;
    assign cmd_ready  = aresetn && (!beat_valid || (beat_hs && beat_last));
    assign cmd_hs     = bus.cmd_valid && cmd_ready;

    axi_beat_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_calc (
        .addr       (addr_q),
        .size       (size_q),
        .burst      (burst_q),
        .wrap_lower (wrap_lower_q),
        .wrap_bytes (wrap_bytes_q),
        .next_addr  (next_addr)
    );

    always_comb begin
        cmd_size_mask   = (ONE << bus.cmd_size) - ONE;
        cmd_wrap_bytes  = (ADDR_WIDTH'(bus.cmd_len) + ONE) << bus.cmd_size;
        cmd_incr_end    = (bus.cmd_addr & ~cmd_size_mask) + cmd_wrap_bytes - ONE;
        cmd_wrap        = (bus.cmd_burst == BURST_WRAP);
        cmd_wrap_len_ok = (bus.cmd_len == LEN_WIDTH'(1)) || (bus.cmd_len == LEN_WIDTH'(3)) ||
                          (bus.cmd_len == LEN_WIDTH'(7)) || (bus.cmd_len == LEN_WIDTH'(15));
        // 4 KB crossing: first and last byte differ above the page offset
        cmd_err = (bus.cmd_size > MAX_SIZE) ||
                  (bus.cmd_burst == BURST_RSVD) ||
                  (cmd_wrap && !cmd_wrap_len_ok) ||
                  (cmd_wrap && |(bus.cmd_addr & cmd_size_mask)) ||
                  ((bus.cmd_burst == BURST_INCR) && |((bus.cmd_addr ^ cmd_incr_end) & ~PAGE_MASK));
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        wrap_lower_d = wrap_lower_q;
        wrap_bytes_d = wrap_bytes_q;
        idx_d        = idx_q;
        err_valid_d  = 1'b0;
        err_id_d     = err_id_q;
        if (beat_hs) begin
            addr_d = next_addr;
            if (beat_last) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + LEN_WIDTH'(1);
            end
        end
        if (cmd_hs) begin
            if (cmd_err) begin
                err_valid_d = 1'b1;
                err_id_d    = bus.cmd_id;
            end else begin
                state_d      = ST_BURST;
                id_d         = bus.cmd_id;
                addr_d       = bus.cmd_addr;
                len_d        = bus.cmd_len;
                size_d       = bus.cmd_size;
                burst_d      = burst_e'(bus.cmd_burst);
                wrap_lower_d = bus.cmd_addr & ~(cmd_wrap_bytes - ONE);
                wrap_bytes_d = cmd_wrap_bytes;
                idx_d        = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= BURST_FIXED;
            wrap_lower_q <= '0;
            wrap_bytes_q <= '0;
            idx_q        <= '0;
            err_valid_q  <= 1'b0;
            err_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            wrap_lower_q <= wrap_lower_d;
            wrap_bytes_q <= wrap_bytes_d;
            idx_q        <= idx_d;
            err_valid_q  <= err_valid_d;
            err_id_q     <= err_id_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.beat_valid = beat_valid;
    assign bus.beat_id    = id_q;
    assign bus.beat_addr  = addr_q;
    assign bus.beat_lane  = addr_q[LANE_WIDTH-1:0];
    assign bus.beat_idx   = idx_q;
    assign bus.beat_last  = beat_last;
    assign bus.err_valid  = err_valid_q;
    assign bus.err_id     = err_id_q;

endmodule
